// File: rtl/dma_arbiter.sv
// dma_arbiter: shares a 1-cycle-latency synchronous RAM between a 6502-style CPU port and an ANTIC-style DMA read port.
// Optional macro DMA_ARB_FAIRNESS_EN: caps a DMA burst at DMA_MAX_BURST grants while a CPU read waits.
`timescale 1ns/1ps

module dma_arbiter #(
    parameter int DMA_MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        HALT,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CPU_ISSUE = 3'd1,
        CPU_DATA  = 3'd2,
        DMA_ISSUE = 3'd3,
        DMA_DATA  = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        grant_cpu;
    logic        grant_dma;
    logic        cpu_wr_pend;
    logic        cpu_rd_pend;
    logic        dma_win;

    logic [15:0] mem_addr_reg;
    logic        mem_we_reg;
    logic [7:0]  mem_wdata_reg;
    logic        cpu_read_reg;
    logic [7:0]  cpu_rdata_reg;
    logic [7:0]  dma_rdata_reg;
    logic        halt_reg;

    assign cpu_wr_pend = cpu_req & ~cpu_rw;
    assign cpu_rd_pend = cpu_req & cpu_rw;

`ifdef DMA_ARB_FAIRNESS_EN
    localparam logic [7:0] BURST_MAX = 8'(DMA_MAX_BURST);

    logic [7:0] burst_cnt_reg;
    logic [7:0] burst_cnt_next;
    logic       arb_point;

    assign arb_point = (state_reg == IDLE) || (state_reg == CPU_DATA) || (state_reg == DMA_DATA);

    // A full burst yields exactly one slot to a waiting CPU read.
    assign dma_win = dma_req & ~(cpu_rd_pend && (burst_cnt_reg == BURST_MAX));

    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (grant_cpu) begin
            burst_cnt_next = 8'd0;
        end else if (grant_dma) begin
            if (burst_cnt_reg < BURST_MAX) begin
                burst_cnt_next = burst_cnt_reg + 8'd1;
            end
        end else if (arb_point && !dma_req) begin
            burst_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            burst_cnt_reg <= 8'd0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    // Without the fairness counter DMA_MAX_BURST has no effect.
    logic unused_burst_cfg;
    assign unused_burst_cfg = ^(8'(DMA_MAX_BURST));
    assign dma_win          = dma_req;
`endif

    always_comb begin
        state_next = state_reg;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        case (state_reg)
            CPU_ISSUE: state_next = CPU_DATA;
            DMA_ISSUE: state_next = DMA_DATA;
            default: begin
                // Arbitration point: IDLE, CPU_DATA or DMA_DATA.
                if (cpu_wr_pend) begin
                    grant_cpu  = 1'b1;
                    state_next = CPU_ISSUE;
                end else if (dma_win) begin
                    grant_dma  = 1'b1;
                    state_next = DMA_ISSUE;
                end else if (cpu_rd_pend) begin
                    grant_cpu  = 1'b1;
                    state_next = CPU_ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg     <= IDLE;
            mem_addr_reg  <= 16'd0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= 8'd0;
            cpu_read_reg  <= 1'b0;
            cpu_rdata_reg <= 8'd0;
            dma_rdata_reg <= 8'd0;
            halt_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halt_reg   <= dma_req | (state_reg == DMA_ISSUE) | (state_reg == DMA_DATA);
            mem_we_reg <= 1'b0;
            // The granted request is latched so the access completes even if it drops.
            if (grant_cpu) begin
                mem_addr_reg  <= cpu_addr;
                mem_we_reg    <= ~cpu_rw;
                mem_wdata_reg <= cpu_wdata;
                cpu_read_reg  <= cpu_rw;
            end else if (grant_dma) begin
                mem_addr_reg  <= dma_addr;
            end
            if ((state_reg == CPU_DATA) && cpu_read_reg) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (state_reg == DMA_DATA) begin
                dma_rdata_reg <= mem_rdata;
            end
        end
    end

    always_comb begin
        owner = 2'b00;
        case (state_reg)
            CPU_ISSUE, CPU_DATA: owner = 2'b01;
            DMA_ISSUE, DMA_DATA: owner = 2'b10;
            default:             owner = 2'b00;
        endcase
    end

    assign cpu_ack   = (state_reg == CPU_DATA);
    assign dma_ack   = (state_reg == DMA_DATA);
    // Read data is forwarded during DATA so it is valid alongside the ack.
    assign cpu_rdata = ((state_reg == CPU_DATA) && cpu_read_reg) ? mem_rdata : cpu_rdata_reg;
    assign dma_rdata = dma_ack ? mem_rdata : dma_rdata_reg;
    assign HALT      = halt_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: requester drivers, a synchronous RAM model and an ack monitor.
`timescale 1ns/1ps

module tb_dma_arbiter;

    localparam logic [15:0] DMA_BASE = 16'h2000;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        HALT;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;

    logic [7:0]  ram [0:65535];

    typedef struct packed {
        logic       is_dma;
        logic       chk;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cpu_op_t;

    exp_t    exp_tab [0:63];
    int      exp_wr = 0;
    int      exp_rd = 0;
    cpu_op_t cpu_tab [0:15];
    int      cpu_tab_n = 0;
    int      cpu_pos = 0;
    int      dma_cmd_n = 0;
    int      dma_seq = 0;
    int      dma_seq_seen = 0;
    int      dma_left = 0;
    int      dma_idx = 0;
    int      checks = 0;
    int      failures = 0;

    dma_arbiter #(.DMA_MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .HALT      (HALT),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    initial forever #5 clk = ~clk;

    // Synchronous RAM, one cycle read latency.
    initial begin
        ram[16'h0000] <= 8'h11;
        ram[16'h0001] <= 8'h22;
        ram[16'h0100] <= 8'h77;
        ram[16'h1234] <= 8'hA5;
        for (int i = 0; i < 32; i++) begin
            ram[DMA_BASE + 16'(i)] <= 8'(8'h80 + i);
        end
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic is_dma, input logic chk, input logic [7:0] d);
        exp_tab[exp_wr] = '{is_dma, chk, d};
        exp_wr++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
        check({tag, "_dma_ack"},   32'(dma_ack),   32'd0);
        check({tag, "_halt"},      32'(HALT),      32'd0);
        check({tag, "_owner"},     32'(owner),     32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_dma_rdata"}, 32'(dma_rdata), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_rd == exp_wr) break;
            @(negedge clk);
        end
        check({name, "_drain"}, 32'(exp_rd == exp_wr), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // CPU driver: holds each access until its ack, then presents the next one immediately.
    initial begin
        cpu_req   = 1'b0;
        cpu_rw    = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        forever begin
            @(negedge clk);
            if (cpu_req && cpu_ack) cpu_req = 1'b0;
            if (!cpu_req && (cpu_pos < cpu_tab_n)) begin
                cpu_rw    = cpu_tab[cpu_pos].rw;
                cpu_addr  = cpu_tab[cpu_pos].addr;
                cpu_wdata = cpu_tab[cpu_pos].wdata;
                cpu_req   = 1'b1;
                cpu_pos++;
            end
        end
    end

    // DMA driver: a new command (dma_seq bump) starts a burst of dma_cmd_n sequential reads.
    initial begin
        dma_req  = 1'b0;
        dma_addr = 16'h0000;
        forever begin
            @(negedge clk);
            if (dma_seq_seen != dma_seq) begin
                dma_seq_seen = dma_seq;
                dma_left     = dma_cmd_n;
                dma_idx      = 0;
                dma_addr     = DMA_BASE;
                dma_req      = (dma_left > 0);
            end else if (dma_req && dma_ack) begin
                dma_idx++;
                dma_left--;
                dma_addr = DMA_BASE + 16'(dma_idx);
                if (dma_left == 0) dma_req = 1'b0;
            end
        end
    end

    // Monitor: every ack is matched, in order, against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                $display("ack %s rdata=0x%02h t=%0t", dma_ack ? "dma" : "cpu",
                         dma_ack ? dma_rdata : cpu_rdata, $time);
                check("single_ack", 32'(cpu_ack & dma_ack), 32'd0);
                check("ack_pending", 32'(exp_rd < exp_wr), 32'd1);
                if (exp_rd < exp_wr) begin
                    e = exp_tab[exp_rd];
                    exp_rd++;
                    check("ack_source", 32'(dma_ack), 32'(e.is_dma));
                    if (e.chk) check("ack_rdata", 32'(dma_ack ? dma_rdata : cpu_rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_L = 1'b0;
        settle(2);
        check_all_zero("reset");
        rst_L = 1'b1;
        settle(1);

        // Single CPU read of 0x1234.
        cpu_tab[0] = '{1'b1, 16'h1234, 8'h00};
        cpu_tab_n  = 1;
        push(1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        check("rd_issue_owner", 32'(owner),    32'd1);
        check("rd_issue_addr",  32'(mem_addr), 32'h1234);
        check("rd_issue_we",    32'(mem_we),   32'd0);
        check("rd_issue_halt",  32'(HALT),     32'd0);
        wait_drain("rd", 20);
        check("rd_done_owner",  32'(owner),    32'd0);
        check("rd_done_halt",   32'(HALT),     32'd0);
        settle(2);

        // Back-to-back CPU reads of 0x0000 and 0x0001.
        cpu_tab[1] = '{1'b1, 16'h0000, 8'h00};
        cpu_tab[2] = '{1'b1, 16'h0001, 8'h00};
        cpu_tab_n  = 3;
        push(1'b0, 1'b1, 8'h11);
        push(1'b0, 1'b1, 8'h22);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("b2b_ack0",       32'(cpu_ack),  32'd1);
        @(negedge clk);
        check("b2b_gap_ack",    32'(cpu_ack),  32'd0);
        check("b2b_gap_owner",  32'(owner),    32'd1);
        check("b2b_gap_addr",   32'(mem_addr), 32'h0001);
        @(negedge clk);
        check("b2b_ack1",       32'(cpu_ack),  32'd1);
        wait_drain("b2b", 20);
        settle(2);

        // CPU write 0xF800 := 0x3C racing a DMA request; write goes first.
        cpu_tab[3] = '{1'b0, 16'hF800, 8'h3C};
        cpu_tab_n  = 4;
        dma_cmd_n  = 1;
        dma_seq++;
        push(1'b0, 1'b1, 8'h22);
        push(1'b1, 1'b1, 8'h80);
        @(negedge clk);
        @(negedge clk);
        check("wr_issue_we",    32'(mem_we),    32'd1);
        check("wr_issue_addr",  32'(mem_addr),  32'hF800);
        check("wr_issue_wdata", 32'(mem_wdata), 32'h3C);
        check("wr_issue_owner", 32'(owner),     32'd1);
        check("wr_issue_halt",  32'(HALT),      32'd1);
        @(negedge clk);
        check("wr_data_we",     32'(mem_we),    32'd0);
        check("wr_data_ack",    32'(cpu_ack),   32'd1);
        @(negedge clk);
        check("wr_dma_owner",   32'(owner),     32'd2);
        check("wr_dma_addr",    32'(mem_addr),  32'(DMA_BASE));
        wait_drain("wr", 20);
        settle(3);
        check("wr_ram", 32'(ram[16'hF800]), 32'h3C);

        // HALT timing around a single DMA access.
        dma_cmd_n = 1;
        dma_seq++;
        push(1'b1, 1'b1, 8'h80);
        @(negedge clk);
        check("halt_before",    32'(HALT),    32'd0);
        @(negedge clk);
        check("halt_issue",     32'(HALT),    32'd1);
        check("halt_owner",     32'(owner),   32'd2);
        @(negedge clk);
        check("halt_data_ack",  32'(dma_ack), 32'd1);
        @(negedge clk);
        check("halt_lag",       32'(HALT),    32'd1);
        check("halt_idle",      32'(owner),   32'd0);
        @(negedge clk);
        check("halt_fall",      32'(HALT),    32'd0);
        wait_drain("halt", 20);
        settle(2);

        // 20-access DMA burst with a CPU read of 0x0100 waiting.
        cpu_tab[4] = '{1'b1, 16'h0100, 8'h00};
        cpu_tab_n  = 5;
        dma_cmd_n  = 20;
        dma_seq++;
`ifdef DMA_ARB_FAIRNESS_EN
        for (int i = 0; i < 8; i++) push(1'b1, 1'b1, 8'(8'h80 + i));
        push(1'b0, 1'b1, 8'h77);
        for (int i = 8; i < 20; i++) push(1'b1, 1'b1, 8'(8'h80 + i));
`else
        for (int i = 0; i < 20; i++) push(1'b1, 1'b1, 8'(8'h80 + i));
        push(1'b0, 1'b1, 8'h77);
`endif
        wait_drain("burst", 200);
        settle(3);

        // Reset during DMA_ISSUE aborts the access; a reapplied request then completes.
        dma_cmd_n = 1;
        dma_seq++;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_owner", 32'(owner), 32'd2);
        rst_L = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        dma_cmd_n = 0;
        dma_seq++;
        settle(3);
        check("midrst_hold_ack", 32'(dma_ack), 32'd0);
        rst_L = 1'b1;
        settle(1);
        dma_cmd_n = 1;
        dma_seq++;
        push(1'b1, 1'b1, 8'h80);
        @(negedge clk);
        @(negedge clk);
        check("rst_re_owner", 32'(owner),   32'd2);
        @(negedge clk);
        check("rst_re_ack",   32'(dma_ack), 32'd1);
        wait_drain("rst", 20);
        settle(3);

        check("scoreboard_left", 32'(exp_wr - exp_rd), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter DMA_MAX_BURST, default 8, sets the maximum number of consecutive DMA grants while a CPU read waits (1..255).
REQ-002 clk  input  1  system clock (the fast, 2x-phi1 memory clock); all state changes on its rising edge.
REQ-003 rst_L  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request, level, held with cpu_addr/cpu_rw/cpu_wdata stable until cpu_ack.
REQ-005 cpu_rw  input  1  1 = read, 0 = write (6502 RW sense).
REQ-006 cpu_addr  input  16  CPU address; cpu_wdata  input  8  CPU write data.
REQ-007 cpu_ack  output  1  one-cycle pulse, access complete; cpu_rdata  output  8  read data, valid with cpu_ack and held until the next CPU read ack.
REQ-008 dma_req  input  1  DMA (ANTIC) read request, level, held with dma_addr stable until dma_ack.
REQ-009 dma_addr  input  16  DMA address; dma_ack  output  1  one-cycle completion pulse; dma_rdata  output  8  valid with dma_ack, held until the next DMA ack.
REQ-010 HALT  output  1  registered, high = stall CPU read cycles (drives the CPU HALT/RDY path).
REQ-011 mem_addr  output  16  RAM address; mem_we  output  1  RAM write enable; mem_wdata  output  8  RAM write data; mem_rdata  input  8  RAM read data, synchronous, 1-cycle latency.
REQ-012 owner  output  2  debug: 00 idle, 01 CPU, 10 DMA, 11 never driven.

Function
REQ-013 FSM states SHALL be IDLE, CPU_ISSUE, CPU_DATA, DMA_ISSUE, DMA_DATA; every access SHALL take exactly 2 clk (ISSUE then DATA).
REQ-014 Arbitration SHALL occur in IDLE and in CPU_DATA/DMA_DATA, so back-to-back accesses have no idle cycle.
REQ-015 Priority: (1) a pending CPU write; (2) dma_req, subject to REQ-021; (3) a pending CPU read; (4) otherwise go to IDLE.
REQ-016 A CPU write SHALL never be stalled, because the 6502 cannot halt on write cycles; it wins even while HALT is high.
REQ-017 In ISSUE, mem_addr SHALL equal the granted requester's address, and mem_we SHALL be 1 only for a CPU write, with mem_wdata = cpu_wdata.
REQ-018 In DATA, the arbiter SHALL capture mem_rdata into cpu_rdata or dma_rdata (reads only) and pulse the matching ack; mem_we SHALL be 0.
REQ-019 Once ISSUE is entered, the access SHALL complete and be acked even if the request drops; a request that is not held is a protocol violation, with no further guarantee.
REQ-020 HALT SHALL be registered as (dma_req | state in {DMA_ISSUE, DMA_DATA}), giving a 1-cycle lag; HALT SHALL fall 1 clk after the last DMA_DATA when dma_req is low.
REQ-021 Burst counter (8-bit): increments on each DMA grant, clears on any CPU grant or when dma_req is low at an arbitration point, and saturates at DMA_MAX_BURST (fairness, REQ-026).
REQ-022 Simultaneous new cpu_req (read) and dma_req in IDLE: DMA wins; the CPU read is served after the DMA, or after DMA_MAX_BURST grants.
REQ-023 owner SHALL reflect the current state's requester; IDLE gives 00.

Reset
REQ-024 rst_L low SHALL immediately force: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_ack 0, dma_ack 0, cpu_rdata 0, dma_rdata 0, HALT 0, owner 00, burst counter 0.
REQ-025 Reset during ISSUE or DATA SHALL abort the access with no ack; after rst_L rises, arbitration SHALL resume on the first clk edge.

Configuration
REQ-026 Macro DMA_ARB_FAIRNESS_EN defined: when the burst counter equals DMA_MAX_BURST and a CPU read is pending, the next slot SHALL go to the CPU.
REQ-027 Macro DMA_ARB_FAIRNESS_EN undefined: strict DMA priority over CPU reads; the counter logic is not built and DMA_MAX_BURST is ignored.

Verification
REQ-028 CPU read 0x1234 with RAM[0x1234]=0xA5, no DMA -> mem_addr=0x1234 in CPU_ISSUE; cpu_ack pulses 2 clk after grant with cpu_rdata=0xA5; HALT stays 0.
REQ-029 CPU write 0xF800 := 0x3C while dma_req is high -> the CPU write is granted first with mem_we=1 for exactly 1 clk; DMA is granted in the following ISSUE; RAM[0xF800]=0x3C.
REQ-030 dma_req held for 20 accesses, CPU read pending, fairness enabled with DMA_MAX_BURST=8 -> 8 dma_acks, then 1 cpu_ack, then DMA resumes; with the macro undefined, 20 dma_acks occur before the cpu_ack.
REQ-031 dma_req rises in IDLE -> HALT=1 on the next edge; dma_req drops after a single ack -> HALT returns to 0 one clk after DMA_DATA.
REQ-032 rst_L pulsed low during DMA_ISSUE -> no dma_ack, and all outputs are 0 while reset is low; a request reapplied after reset completes normally in 2 clk.
REQ-033 Back-to-back CPU reads 0x0000, 0x0001 -> cpu_ack pulses on consecutive DATA cycles 2 clk apart, with no IDLE between them.
